// File: rtl/priority_arbiter_4ch.sv
// priority_arbiter_4ch: shares one downstream resource among four requesters.
// Fixed-priority (3 highest) or round-robin selection, with grant hold until
// release or a MAX_HOLD-cycle timeout, and back-to-back handover on release.
module priority_arbiter_4ch #(
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_lines,
    output logic [3:0] grant_lines,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Hold count value at which the owner has used up its MAX_HOLD cycles.
    localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);

    state_t     state, state_next;
    logic [7:0] hold_cnt, hold_cnt_next;
    logic [1:0] last_id, last_id_next;
    logic [3:0] grant_next;
    logic [1:0] id_next;
    logic       pulse_next;
    logic       owner_req;
    logic       forced;
    logic       release_now;
    logic [3:0] masked_req;
    logic [2:0] win;

    // Returns {found, index}. Fixed mode: highest set bit. Round-robin mode:
    // first set bit in the order last+1, last+2, last+3, last.
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        if (RR_MODE != 0) begin
            // Walk the order backwards so the nearest candidate is written last.
            for (int k = 4; k >= 1; k--) begin
                idx = last + 2'(k);
                if (req[idx]) r = {1'b1, idx};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign owner_req   = req_lines[grant_id];
    assign forced      = TIMEOUT_EN && owner_req && (hold_cnt == HOLD_LAST);
    assign release_now = !owner_req || forced;
    assign masked_req  = req_lines & ~grant_lines;
    assign grant_valid = |grant_lines;

    // Next-state, next-grant and hold-timer logic.
    always_comb begin
        state_next    = state;
        grant_next    = grant_lines;
        id_next       = grant_id;
        hold_cnt_next = hold_cnt;
        last_id_next  = last_id;
        pulse_next    = 1'b0;
        win           = 3'b000;
        case (state)
            IDLE: begin
                win = pick(req_lines, last_id);
                if (win[2]) begin
                    state_next    = OWNED;
                    grant_next    = 4'b0001 << win[1:0];
                    id_next       = win[1:0];
                    last_id_next  = win[1:0];
                    hold_cnt_next = 8'd0;
                end
            end
            OWNED: begin
                if (release_now) begin
                    // The current owner is masked off so a waiting requester
                    // always takes over without an idle cycle.
                    win        = pick(masked_req, last_id);
                    pulse_next = forced;
                    if (win[2]) begin
                        grant_next    = 4'b0001 << win[1:0];
                        id_next       = win[1:0];
                        last_id_next  = win[1:0];
                        hold_cnt_next = 8'd0;
                    end else begin
                        state_next    = IDLE;
                        grant_next    = 4'b0000;
                        id_next       = 2'd0;
                        hold_cnt_next = 8'd0;
                    end
                end else if (hold_cnt != 8'hFF) begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
                id_next    = 2'd0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_lines   <= 4'b0000;
            grant_id      <= 2'd0;
            timeout_pulse <= 1'b0;
            hold_cnt      <= 8'd0;
            last_id       <= 2'd3;
        end else begin
            state         <= state_next;
            grant_lines   <= grant_next;
            grant_id      <= id_next;
            timeout_pulse <= pulse_next;
            hold_cnt      <= hold_cnt_next;
            last_id       <= last_id_next;
        end
    end

endmodule
